bcd_operand_loader: RTL and testbench

//  Upstream stage of the 8-digit BCD multiplier. Collects one BCD digit per handshake
//  (keypad/UART stream, MSD first): 8 digits of operand A, then 8 of B.

---
 rtl/bcd_operand_loader_pkg.sv | 18 +
 rtl/bcd_operand_loader_if.sv | 25 ++
 rtl/bcd_digit_check.sv | 11 +
 rtl/bcd_operand_loader.sv | 116 +++++++++++
 tb/tb_bcd_operand_loader.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/bcd_operand_loader_pkg.sv
// Shared definitions for the BCD operand loader: digit limits, default sizes
// and the loader state encoding.
package bcd_operand_loader_pkg;

    localparam int          BCD_DIG_W = 4;
    localparam logic [3:0]  BCD_MAX   = 4'd9;

    localparam int NDIG_DEF  = 8;
    localparam int CNT_W_DEF = 3;

    // Encoding 2'd3 is unused and steers back to ST_LOAD_A.
    typedef enum logic [1:0] {
        ST_LOAD_A  = 2'd0,
        ST_LOAD_B  = 2'd1,
        ST_PRESENT = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_operand_loader_if.sv
// Digit stream and operand-pair handshake between the loader, its digit
// source and the downstream multiplier.
interface bcd_operand_loader_if #(
    parameter int NDIG = 8
);

    logic [3:0]        digit_in;
    logic              digit_valid;
    logic              digit_ready;
    logic [4*NDIG-1:0] op_a;
    logic [4*NDIG-1:0] op_b;
    logic              op_valid;
    logic              op_ready;

    modport master (
        output digit_in, digit_valid, op_ready,
        input  digit_ready, op_a, op_b, op_valid
    );

    modport slave (
        input  digit_in, digit_valid, op_ready,
        output digit_ready, op_a, op_b, op_valid
    );

endinterface

// File: rtl/bcd_digit_check.sv
// Combinational BCD digit qualifier; also used by the result-formatting stage.
module bcd_digit_check
    import bcd_operand_loader_pkg::*;
(
    input  logic [BCD_DIG_W-1:0] digit,
    output logic                 is_bcd
);

    assign is_bcd = (digit <= BCD_MAX);

endmodule

// File: rtl/bcd_operand_loader.sv
// Collects 2*NDIG BCD digits (MSD first) into packed operands A and B and
// presents the pair to the multiplier with a valid/ready handshake.
module bcd_operand_loader
    import bcd_operand_loader_pkg::*;
#(
    parameter int NDIG  = NDIG_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    bcd_operand_loader_if.slave bus,
    output logic                loading_b,
    output logic [CNT_W-1:0]    dig_cnt,
    output logic                bad_digit,
    output logic                bad_seen
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);

    state_t            state;
    state_t            state_next;
    logic              started;
    logic              is_bcd;
    logic              accept;
    logic              good_accept;
    logic              bad_accept;
    logic              last_digit;
    logic [4*NDIG-1:0] op_a;
    logic [4*NDIG-1:0] op_b;

    bcd_digit_check u_digit_check (
        .digit  (bus.digit_in),
        .is_bcd (is_bcd)
    );

    assign accept      = bus.digit_valid & bus.digit_ready;
    assign good_accept = accept & is_bcd;
    assign bad_accept  = accept & ~is_bcd;
    assign last_digit  = (dig_cnt == LAST_CNT);

    assign bus.op_a = op_a;
    assign bus.op_b = op_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_LOAD_A;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (clr) begin
            state_next = ST_LOAD_A;
        end else begin
            case (state)
                ST_LOAD_A:  if (good_accept && last_digit) state_next = ST_LOAD_B;
                ST_LOAD_B:  if (good_accept && last_digit) state_next = ST_PRESENT;
                ST_PRESENT: if (bus.op_ready)              state_next = ST_LOAD_A;
                default:                                   state_next = ST_LOAD_A;
            endcase
        end
    end

    // Outputs come only from registers; 'started' keeps digit_ready low during reset.
    always_comb begin
        bus.digit_ready = 1'b0;
        bus.op_valid    = 1'b0;
        loading_b       = 1'b0;
        case (state)
            ST_LOAD_A:  bus.digit_ready = started;
            ST_LOAD_B: begin
                bus.digit_ready = started;
                loading_b       = 1'b1;
            end
            ST_PRESENT: bus.op_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            started <= 1'b0;
        else
            started <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a      <= '0;
            op_b      <= '0;
            dig_cnt   <= '0;
            bad_digit <= 1'b0;
            bad_seen  <= 1'b0;
        end else if (clr) begin
            op_a      <= '0;
            op_b      <= '0;
            dig_cnt   <= '0;
            bad_digit <= 1'b0;
            bad_seen  <= 1'b0;
        end else begin
            bad_digit <= bad_accept;
            if (bad_accept)
                bad_seen <= 1'b1;
            if (good_accept) begin
                if (state == ST_LOAD_A)
                    op_a <= {op_a[4*NDIG-5:0], bus.digit_in};
                else
                    op_b <= {op_b[4*NDIG-5:0], bus.digit_in};
                dig_cnt <= last_digit ? '0 : dig_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bcd_operand_loader.sv
// Directed self-checking bench for bcd_operand_loader: reset, nominal load,
// bad digits, backpressure, clear and asynchronous reset mid-load.
module tb_bcd_operand_loader;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       loading_b;
    logic [2:0] dig_cnt;
    logic       bad_digit;
    logic       bad_seen;

    int n_checks;
    int n_fail;

    bcd_operand_loader_if #(.NDIG(8)) bus ();

    bcd_operand_loader #(.NDIG(8), .CNT_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .bus       (bus),
        .loading_b (loading_b),
        .dig_cnt   (dig_cnt),
        .bad_digit (bad_digit),
        .bad_seen  (bad_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs at a falling edge; outputs are stable at the next one.
    task automatic step(input logic valid, input logic [3:0] digit);
        bus.digit_valid = valid;
        bus.digit_in    = digit;
        @(negedge clk);
    endtask

    task automatic feed(input logic [31:0] value);
        for (int i = 7; i >= 0; i--)
            step(1'b1, value[4*i +: 4]);
        bus.digit_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] bval;
        n_checks        = 0;
        n_fail          = 0;
        rst_n           = 1'b1;
        clr             = 1'b0;
        bus.digit_in    = 4'd0;
        bus.digit_valid = 1'b0;
        bus.op_ready    = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);

        check("rst_op_a",        bus.op_a,                0);
        check("rst_op_b",        bus.op_b,                0);
        check("rst_op_valid",    32'(bus.op_valid),       0);
        check("rst_digit_ready", 32'(bus.digit_ready),    0);
        check("rst_dig_cnt",     32'(dig_cnt),            0);
        check("rst_loading_b",   32'(loading_b),          0);
        check("rst_bad_digit",   32'(bad_digit),          0);
        check("rst_bad_seen",    32'(bad_seen),           0);

        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 4'd0);
        check("post_rst_digit_ready", 32'(bus.digit_ready), 1);
        check("post_rst_op_valid",    32'(bus.op_valid),    0);

        // Nominal pair, back-to-back digits.
        feed(32'h12345678);
        check("nom_op_a",      bus.op_a,          32'h12345678);
        check("nom_loading_b", 32'(loading_b),    1);
        check("nom_cnt_wrap",  32'(dig_cnt),      0);
        bval = 32'h87654321;
        for (int i = 7; i >= 1; i--)
            step(1'b1, bval[4*i +: 4]);
        check("nom_cnt_7",          32'(dig_cnt),      7);
        check("nom_valid_before",   32'(bus.op_valid), 0);
        step(1'b1, 4'd1);
        bus.digit_valid = 1'b0;
        check("nom_op_valid",    32'(bus.op_valid),    1);
        check("nom_op_b",        bus.op_b,             32'h87654321);
        check("nom_digit_ready", 32'(bus.digit_ready), 0);
        check("nom_loading_b_0", 32'(loading_b),       0);

        // Backpressure while presenting: offered digit must be refused.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'd5);
            check("bp_op_a",        bus.op_a,             32'h12345678);
            check("bp_op_b",        bus.op_b,             32'h87654321);
            check("bp_op_valid",    32'(bus.op_valid),    1);
            check("bp_digit_ready", 32'(bus.digit_ready), 0);
        end
        bus.op_ready = 1'b1;
        step(1'b0, 4'd0);
        bus.op_ready = 1'b0;
        check("hs_op_valid",    32'(bus.op_valid),    0);
        check("hs_digit_ready", 32'(bus.digit_ready), 1);
        check("hs_op_a_kept",   bus.op_a,             32'h12345678);
        check("hs_dig_cnt",     32'(dig_cnt),         0);

        // Bad digit after the third digit of A.
        step(1'b1, 4'd9);
        step(1'b1, 4'd0);
        step(1'b1, 4'd1);
        step(1'b1, 4'hB);
        check("bad_pulse",    32'(bad_digit), 1);
        check("bad_seen",     32'(bad_seen),  1);
        check("bad_cnt",      32'(dig_cnt),   3);
        check("bad_op_a",     bus.op_a,       32'h45678901);
        step(1'b0, 4'hF);
        check("bad_pulse_end", 32'(bad_digit), 0);
        check("bad_seen_hold", 32'(bad_seen),  1);
        step(1'b1, 4'd2);
        step(1'b1, 4'd3);
        step(1'b1, 4'd4);
        step(1'b1, 4'd5);
        step(1'b1, 4'd6);
        check("bad_final_op_a", bus.op_a,       32'h90123456);
        check("bad_loading_b",  32'(loading_b), 1);

        // Clear in the middle of B with a simultaneous digit.
        step(1'b1, 4'd1);
        step(1'b1, 4'd2);
        step(1'b1, 4'd3);
        step(1'b1, 4'd4);
        check("clr_pre_cnt",  32'(dig_cnt), 4);
        check("clr_pre_op_b", bus.op_b,     32'h43211234);
        clr = 1'b1;
        step(1'b1, 4'd7);
        clr = 1'b0;
        bus.digit_valid = 1'b0;
        check("clr_op_a",        bus.op_a,             0);
        check("clr_op_b",        bus.op_b,             0);
        check("clr_dig_cnt",     32'(dig_cnt),         0);
        check("clr_loading_b",   32'(loading_b),       0);
        check("clr_bad_seen",    32'(bad_seen),        0);
        check("clr_digit_ready", 32'(bus.digit_ready), 1);

        // Asynchronous reset while loading B.
        feed(32'h11223344);
        step(1'b1, 4'd9);
        step(1'b1, 4'd9);
        check("mid_loading_b", 32'(loading_b), 1);
        check("mid_dig_cnt",   32'(dig_cnt),   2);
        bus.digit_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_op_a",        bus.op_a,             0);
        check("arst_op_b",        bus.op_b,             0);
        check("arst_dig_cnt",     32'(dig_cnt),         0);
        check("arst_loading_b",   32'(loading_b),       0);
        check("arst_digit_ready", 32'(bus.digit_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 4'hF);
        check("arst_no_bad",      32'(bad_digit),       0);
        check("arst_ready_again", 32'(bus.digit_ready), 1);

        feed(32'h98765432);
        feed(32'h01010101);
        check("fresh_op_valid", 32'(bus.op_valid), 1);
        check("fresh_op_a",     bus.op_a,          32'h98765432);
        check("fresh_op_b",     bus.op_b,          32'h01010101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
